// File: rtl/query_patch_wb_reader.sv
// Wishbone read responder for the query patch memory: returns a stored patch as two 32-bit halves.
// Optional one-entry read cache enabled with `define PATCH_CACHE_EN.
module query_patch_wb_reader #(
  parameter int DATA_WIDTH        = 11,
  parameter int PATCH_SIZE        = 5,
  parameter int ADDR_WIDTH        = 9,
  parameter int DEPTH             = 512,
  parameter int WB_ADDRESS_OFFSET = 557
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  input  logic                  wb_mode,
  input  logic                  wbs_stb_i,
  input  logic                  wbs_cyc_i,
  input  logic                  wbs_we_i,
  input  logic [31:0]           wbs_adr_i,
  output logic                  wbs_ack_o,
  output logic [31:0]           wbs_dat_o,
  output logic                  ram_csb,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  input  logic [63:0]           ram_rdata
);

  localparam int          PATCH_W    = DATA_WIDTH * PATCH_SIZE;
  localparam logic [63:0] PATCH_MASK = (PATCH_W >= 64) ? {64{1'b1}}
                                                       : ((64'd1 << PATCH_W) - 64'd1);
  localparam logic [31:0] WIN_BASE   = 32'(WB_ADDRESS_OFFSET);
  localparam logic [31:0] WIN_SPAN   = 32'(2 * DEPTH);

  if (PATCH_W > 64) begin : g_patch_too_wide
    $error("patch width exceeds the 64-bit memory word");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_ACK
  } state_t;

  // Bits above the patch width are forced to zero so stale word padding never leaks out.
  function automatic logic [31:0] select_half(input logic [63:0] word, input logic half);
    logic [63:0] masked;
    masked = word & PATCH_MASK;
    return half ? masked[63:32] : masked[31:0];
  endfunction

  state_t                  state_q, state_d;
  logic                    ack_q, ack_d;
  logic [31:0]             dat_q, dat_d;
  logic                    csb_q, csb_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic                    half_q, half_d;

  logic [31:0]             rel;
  logic                    in_win;
  logic [ADDR_WIDTH-1:0]   req_idx;
  logic                    req_half;
  logic                    rd_req;
  logic                    wr_strobe;
  logic                    cache_hit;
  logic [31:0]             cache_word;

  always_comb begin
    rel       = wbs_adr_i - WIN_BASE;
    in_win    = (wbs_adr_i >= WIN_BASE) && (rel < WIN_SPAN);
    req_idx   = rel[ADDR_WIDTH:1];
    req_half  = rel[0];
    rd_req    = wbs_cyc_i & wbs_stb_i & ~wbs_we_i & wb_mode;
    wr_strobe = wbs_cyc_i & wbs_stb_i & wbs_we_i;
  end

`ifdef PATCH_CACHE_EN
  logic                  cache_vld_q, cache_vld_d;
  logic [ADDR_WIDTH-1:0] cache_tag_q, cache_tag_d;
  logic [63:0]           cache_data_q, cache_data_d;
  logic                  cache_fill;

  always_comb begin
    cache_hit  = cache_vld_q && (cache_tag_q == req_idx);
    cache_word = select_half(cache_data_q, req_half);
  end

  // The write path may change any patch, and mode switches hand the port to the core logic.
  always_comb begin
    cache_fill   = (state_q == S_WAIT);
    cache_vld_d  = cache_vld_q;
    cache_tag_d  = cache_tag_q;
    cache_data_d = cache_data_q;
    if (cache_fill) begin
      cache_vld_d  = 1'b1;
      cache_tag_d  = addr_q;
      cache_data_d = ram_rdata;
    end
    if (wr_strobe || !wb_mode) begin
      cache_vld_d = 1'b0;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      cache_vld_q <= 1'b0;
    end else begin
      cache_vld_q <= cache_vld_d;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    cache_tag_q  <= cache_tag_d;
    cache_data_q <= cache_data_d;
  end
`else
  always_comb begin
    cache_hit  = 1'b0;
    cache_word = 32'd0;
  end
`endif

  always_comb begin
    state_d = state_q;
    ack_d   = 1'b0;
    dat_d   = dat_q;
    csb_d   = 1'b1;
    addr_d  = addr_q;
    half_d  = half_q;
    case (state_q)
      S_IDLE: begin
        if (rd_req) begin
          if (!in_win) begin
            ack_d   = 1'b1;
            dat_d   = 32'd0;
            state_d = S_ACK;
          end else if (cache_hit) begin
            ack_d   = 1'b1;
            dat_d   = cache_word;
            state_d = S_ACK;
          end else begin
            csb_d   = 1'b0;
            addr_d  = req_idx;
            half_d  = req_half;
            state_d = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        ack_d   = 1'b1;
        dat_d   = select_half(ram_rdata, half_q);
        state_d = S_ACK;
      end
      S_ACK: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= S_IDLE;
      ack_q   <= 1'b0;
      dat_q   <= 32'd0;
      csb_q   <= 1'b1;
      addr_q  <= '0;
      half_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      dat_q   <= dat_d;
      csb_q   <= csb_d;
      addr_q  <= addr_d;
      half_q  <= half_d;
    end
  end

  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = dat_q;
  assign ram_csb   = csb_q;
  assign ram_addr  = addr_q;

endmodule

// File: tb/tb_query_patch_wb_reader.sv
// Directed bench for query_patch_wb_reader: miss/hit latency, window bounds, gating and reset.
module tb_query_patch_wb_reader;

`ifdef PATCH_CACHE_EN
  localparam bit CACHE = 1'b1;
`else
  localparam bit CACHE = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        mode;
  logic        stb;
  logic        cyc;
  logic        we;
  logic [31:0] adr;
  logic        ack;
  logic [31:0] dat_o;
  logic        csb;
  logic [8:0]  ram_addr;
  logic [63:0] ram_rdata;
  logic [63:0] mem [512];

  int checks;
  int errors;
  int pulses;
  logic [8:0] last_addr;

  query_patch_wb_reader dut (
    .wb_clk_i  (clk),
    .wb_rst_i  (rst),
    .wb_mode   (mode),
    .wbs_stb_i (stb),
    .wbs_cyc_i (cyc),
    .wbs_we_i  (we),
    .wbs_adr_i (adr),
    .wbs_ack_o (ack),
    .wbs_dat_o (dat_o),
    .ram_csb   (csb),
    .ram_addr  (ram_addr),
    .ram_rdata (ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: dout valid the cycle after the edge that samples csb low.
  always @(posedge clk) begin
    if (!csb) begin
      ram_rdata <= mem[ram_addr];
      pulses    = pulses + 1;
      last_addr = ram_addr;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One read transaction; stb is held through the edge that samples ack, then dropped.
  task automatic wb_read(input logic [31:0] a, output logic [31:0] d, output int lat);
    @(negedge clk);
    pulses = 0;
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = a;
    lat = 0;
    d   = 32'd0;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk); #1;
      if (ack) begin
        lat = i;
        d   = dat_o;
        break;
      end
    end
    @(posedge clk); #1;
    chk("ack_one_cycle", {63'd0, ack}, 64'd0);
    cyc = 1'b0; stb = 1'b0;
    @(posedge clk); #1;
    chk("no_retrigger", {63'd0, ack}, 64'd0);
  endtask

  // Holds a strobe for n cycles and counts acks and memory accesses seen.
  task automatic hold_strobe(input logic m, input logic w, input logic [31:0] a, input int n,
                             output int acks);
    @(negedge clk);
    pulses = 0;
    acks = 0;
    mode = m; cyc = 1'b1; stb = 1'b1; we = w; adr = a;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      if (ack) acks++;
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0; mode = 1'b1;
  endtask

  logic [31:0] d;
  int          lat;
  int          acks;

  initial begin
    checks = 0; errors = 0; pulses = 0; last_addr = '0;
    for (int i = 0; i < 512; i++) mem[i] = 64'h0;
    mem[3]   = 64'h0012_3456_789A_BCDE;
    mem[511] = 64'hFFAB_CDEF_0123_4567;
    rst = 1'b1; mode = 1'b1; stb = 1'b0; cyc = 1'b0; we = 1'b0; adr = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ack", {63'd0, ack}, 64'd0);
    chk("rst_dat", {32'd0, dat_o}, 64'd0);
    chk("rst_csb", {63'd0, csb}, 64'd1);
    chk("rst_addr", {55'd0, ram_addr}, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Miss path, low half of patch 3.
    wb_read(32'd563, d, lat);
    chk("miss_lat", 64'(lat), 64'd3);
    chk("miss_dat", {32'd0, d}, 64'h789A_BCDE);
    chk("miss_pulses", 64'(pulses), 64'd1);
    chk("miss_addr", {55'd0, last_addr}, 64'd3);

    // Second half of the same patch.
    wb_read(32'd564, d, lat);
    chk("half1_dat", {32'd0, d}, 64'h0012_3456);
    chk("half1_lat", 64'(lat), CACHE ? 64'd1 : 64'd3);
    chk("half1_pulses", 64'(pulses), CACHE ? 64'd0 : 64'd1);

    // Window bounds.
    wb_read(32'd556, d, lat);
    chk("below_lat", 64'(lat), 64'd1);
    chk("below_dat", {32'd0, d}, 64'd0);
    chk("below_pulses", 64'(pulses), 64'd0);
    wb_read(32'd1581, d, lat);
    chk("above_lat", 64'(lat), 64'd1);
    chk("above_dat", {32'd0, d}, 64'd0);
    chk("above_pulses", 64'(pulses), 64'd0);
    wb_read(32'd1580, d, lat);
    chk("last_lat", 64'(lat), 64'd3);
    chk("last_dat", {32'd0, d}, 64'h002B_CDEF);
    chk("last_pulses", 64'(pulses), 64'd1);
    chk("last_addr", {55'd0, last_addr}, 64'd511);
    wb_read(32'd5, d, lat);
    chk("wrap_lat", 64'(lat), 64'd1);
    chk("wrap_pulses", 64'(pulses), 64'd0);

    // Invalidation by a Wishbone write.
    wb_read(32'd563, d, lat);
    chk("inv_prime_lat", 64'(lat), 64'd3);
    wb_read(32'd563, d, lat);
    chk("inv_hit_lat", 64'(lat), CACHE ? 64'd1 : 64'd3);
    chk("inv_hit_dat", {32'd0, d}, 64'h789A_BCDE);
    mem[3] = 64'h0000_0000_1111_2222;
    hold_strobe(1'b1, 1'b1, 32'd563, 2, acks);
    chk("write_no_ack", 64'(acks), 64'd0);
    chk("write_no_pulse", 64'(pulses), 64'd0);
    @(negedge clk);
    wb_read(32'd563, d, lat);
    chk("inv_miss_lat", 64'(lat), 64'd3);
    chk("inv_miss_pulses", 64'(pulses), 64'd1);
    chk("inv_miss_dat", {32'd0, d}, 64'h1111_2222);

    // Mode gating and write gating.
    hold_strobe(1'b0, 1'b0, 32'd563, 6, acks);
    chk("mode0_no_ack", 64'(acks), 64'd0);
    chk("mode0_no_pulse", 64'(pulses), 64'd0);
    hold_strobe(1'b1, 1'b1, 32'd600, 5, acks);
    chk("wr_no_ack", 64'(acks), 64'd0);
    chk("wr_no_pulse", 64'(pulses), 64'd0);

    // Reset while the transaction sits in WAIT.
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'd1580;
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b1; cyc = 1'b0; stb = 1'b0;
    @(posedge clk); #1;
    chk("mid_rst_ack", {63'd0, ack}, 64'd0);
    chk("mid_rst_dat", {32'd0, dat_o}, 64'd0);
    chk("mid_rst_csb", {63'd0, csb}, 64'd1);
    chk("mid_rst_addr", {55'd0, ram_addr}, 64'd0);
    rst = 1'b0;
    acks = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (ack) acks++;
    end
    chk("mid_rst_no_ack", 64'(acks), 64'd0);
    wb_read(32'd563, d, lat);
    chk("post_rst_lat", 64'(lat), 64'd3);
    chk("post_rst_dat", {32'd0, d}, 64'h1111_2222);
    chk("post_rst_pulses", 64'(pulses), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
